// File: rtl/jtopl_cendiv.sv
// Purpose: divides the master clock enable down to the operator rate (cenop), keeps the
//          operator slot counter and emits a once-per-frame sample strobe.
// Latency: cenop/cen_smp/mode_ack are registered, one clk after the terminal cen cycle.
// Backpressure: none; cen gaps simply stretch the period (count is in cen cycles).
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   cen             master clock enable
//   mode            ratio select (0: DIV_A, 1: DIV_B), sampled only on terminal cycles
//   cenop           operator-rate enable, one clk wide
//   phase           current divide count
//   slot            current operator slot, aligned with cenop
//   cen_smp         sample strobe, high with cenop when slot is 0
//   mode_ack        one-cycle pulse when a different ratio is adopted
module jtopl_cendiv #(
  parameter int W     = 3,
  parameter int DIV_A = 4,
  parameter int DIV_B = 2,
  parameter int SLOTS = 18,
  parameter int SW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          mode,
  output logic          cenop,
  output logic [W-1:0]  phase,
  output logic [SW-1:0] slot,
  output logic          cen_smp,
  output logic          mode_ack
);

  // Ratios may reach 2^W, so the ratio register is one bit wider than the counter.
  localparam int DW = W + 1;
  localparam logic [DW-1:0] DIV_A_V   = DW'(DIV_A);
  localparam logic [DW-1:0] DIV_B_V   = DW'(DIV_B);
  localparam logic [DW-1:0] ONE_V     = DW'(1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);

  logic [W-1:0]  cnt_q,      cnt_d;
  logic [DW-1:0] div_cur_q,  div_cur_d;
  logic [SW-1:0] slot_q,     slot_d;
  logic          cenop_q,    cenop_d;
  logic          cen_smp_q,  cen_smp_d;
  logic          mode_ack_q, mode_ack_d;

  logic [DW-1:0] div_sel;
  logic          term;

  assign div_sel = mode ? DIV_B_V : DIV_A_V;
  assign term    = cen && ({1'b0, cnt_q} == (div_cur_q - ONE_V));

  always_comb begin
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    slot_d     = slot_q;
    cenop_d    = term;
    cen_smp_d  = term && (slot_q == SLOT_LAST);
    mode_ack_d = term && (div_sel != div_cur_q);

    if (cen) begin
      cnt_d = term ? '0 : cnt_q + 1'b1;
    end

    // The ratio and slot only move on terminal cycles, so a new ratio always
    // starts a fresh period and never truncates the one in progress.
    if (term) begin
      div_cur_d = div_sel;
      slot_d    = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      // Ratio follows mode while reset is held so the first period uses it.
      div_cur_q  <= div_sel;
      // Starting at the last slot makes the first cenop report slot 0.
      slot_q     <= SLOT_LAST;
      cenop_q    <= 1'b0;
      cen_smp_q  <= 1'b0;
      mode_ack_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      slot_q     <= slot_d;
      cenop_q    <= cenop_d;
      cen_smp_q  <= cen_smp_d;
      mode_ack_q <= mode_ack_d;
    end
  end

  assign cenop    = cenop_q;
  assign phase    = cnt_q;
  assign slot     = slot_q;
  assign cen_smp  = cen_smp_q;
  assign mode_ack = mode_ack_q;

endmodule

// File: tb/tb_jtopl_cendiv.sv
module tb_jtopl_cendiv;

  logic       clk;
  logic       rst_n;
  logic       cen;
  logic       mode;
  logic       cenop;
  logic [2:0] phase;
  logic [4:0] slot;
  logic       cen_smp;
  logic       mode_ack;

  int errors = 0;
  int checks = 0;

  jtopl_cendiv #(.W(3), .DIV_A(4), .DIV_B(2), .SLOTS(18), .SW(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .mode     (mode),
    .cenop    (cenop),
    .phase    (phase),
    .slot     (slot),
    .cen_smp  (cen_smp),
    .mode_ack (mode_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it; inputs also change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset with the given mode, release just after a rising edge.
  // The next rising edge is edge 0 of the test.
  task automatic do_reset(input logic m);
    rst_n = 1'b0;
    mode  = m;
    cen   = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mode  = 1'b0;
    cen   = 1'b1;
    tick();
    tick();
    checks++;
    if ({cenop, cen_smp, mode_ack} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {cenop, cen_smp, mode_ack});
    end
    checks++;
    if (phase !== 3'd0) begin
      errors++;
      $display("FAIL reset_phase: got %0d expected 0", phase);
    end
    checks++;
    if (slot !== 5'd17) begin
      errors++;
      $display("FAIL reset_slot: got %0d expected 17", slot);
    end
  endtask

  // Divide by 4 with cen constant: pulses after edges 3,7,11; first pulse is slot 0 with cen_smp.
  task automatic test_div4();
    logic [2:0] exp_flags;
    int p;
    do_reset(1'b0);
    p = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_flags = {(i % 4 == 3), (i == 3), 1'b0};
      checks++;
      if ({cenop, cen_smp, mode_ack} !== exp_flags) begin
        errors++;
        $display("FAIL div4_flags[%0d]: got %b expected %b", i, {cenop, cen_smp, mode_ack}, exp_flags);
      end
      checks++;
      if (phase !== 3'((i + 1) % 4)) begin
        errors++;
        $display("FAIL div4_phase[%0d]: got %0d expected %0d", i, phase, (i + 1) % 4);
      end
      if (i % 4 == 3) begin
        checks++;
        if (slot !== 5'(p)) begin
          errors++;
          $display("FAIL div4_slot[%0d]: got %0d expected %0d", i, slot, p);
        end
        p++;
      end
    end
  endtask

  // cen every 3rd clk: term on cen number 3,7,11 -> edges 9,21,33.
  task automatic test_sparse();
    logic exp_op;
    do_reset(1'b0);
    for (int i = 0; i < 36; i++) begin
      cen = (i % 3 == 0);
      tick();
      exp_op = (i % 3 == 0) && ((i / 3) % 4 == 3);
      checks++;
      if (cenop !== exp_op) begin
        errors++;
        $display("FAIL sparse_cenop[%0d]: got %b expected %b", i, cenop, exp_op);
      end
      checks++;
      if (phase !== 3'((i / 3 + 1) % 4)) begin
        errors++;
        $display("FAIL sparse_phase[%0d]: got %0d expected %0d", i, phase, (i / 3 + 1) % 4);
      end
    end
    cen = 1'b1;
  endtask

  // Divide by 2 from reset (mode=1 during reset); slot steps 0..17 and wraps.
  task automatic test_slot_wrap();
    logic [2:0] exp_flags;
    int p;
    do_reset(1'b1);
    for (int i = 0; i < 76; i++) begin
      tick();
      p = i / 2;
      exp_flags = {(i % 2 == 1), (i % 2 == 1) && (p % 18 == 0), 1'b0};
      checks++;
      if ({cenop, cen_smp, mode_ack} !== exp_flags) begin
        errors++;
        $display("FAIL wrap_flags[%0d]: got %b expected %b", i, {cenop, cen_smp, mode_ack}, exp_flags);
      end
      if (i % 2 == 1) begin
        checks++;
        if (slot !== 5'(p % 18)) begin
          errors++;
          $display("FAIL wrap_slot[%0d]: got %0d expected %0d", i, slot, p % 18);
        end
      end
    end
  endtask

  // mode goes to 1 while phase=1: period completes at 4, then pulses 2 apart.
  task automatic test_mode_switch();
    logic [1:0] exp_flags;
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_flags = {(i == 3) || (i > 3 && i % 2 == 1), (i == 3)};
      checks++;
      if ({cenop, mode_ack} !== exp_flags) begin
        errors++;
        $display("FAIL switch[%0d]: cenop,mode_ack got %b expected %b", i, {cenop, mode_ack}, exp_flags);
      end
      if (i == 0) mode = 1'b1;
    end
  endtask

  // One-clk mode glitch while phase=1 is ignored: no ack, period stays 4.
  task automatic test_mode_glitch();
    logic [1:0] exp_flags;
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_flags = {(i % 4 == 3), 1'b0};
      checks++;
      if ({cenop, mode_ack} !== exp_flags) begin
        errors++;
        $display("FAIL glitch[%0d]: cenop,mode_ack got %b expected %b", i, {cenop, mode_ack}, exp_flags);
      end
      if (i == 0) mode = 1'b1;
      if (i == 1) mode = 1'b0;
    end
  endtask

  // Run to slot=7, phase=2 (edge 33), drop reset between edges, then restart.
  task automatic test_async_reset();
    do_reset(1'b0);
    for (int i = 0; i < 34; i++) tick();
    checks++;
    if ({slot, phase} !== {5'd7, 3'd2}) begin
      errors++;
      $display("FAIL arst_pre: slot,phase got %0d,%0d expected 7,2", slot, phase);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cenop, cen_smp, mode_ack, phase, slot} !== {3'b000, 3'd0, 5'd17}) begin
      errors++;
      $display("FAIL arst_clear: flags %b phase %0d slot %0d expected 000 0 17",
               {cenop, cen_smp, mode_ack}, phase, slot);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({cenop, cen_smp} !== {(i == 3), (i == 3)}) begin
        errors++;
        $display("FAIL arst_restart[%0d]: cenop,cen_smp got %b expected %b", i, {cenop, cen_smp},
                 {(i == 3), (i == 3)});
      end
    end
    checks++;
    if (slot !== 5'd0) begin
      errors++;
      $display("FAIL arst_slot: got %0d expected 0", slot);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cen   = 1'b0;
    mode  = 1'b0;
    test_reset();
    test_div4();
    test_sparse();
    test_slot_wrap();
    test_mode_switch();
    test_mode_glitch();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
